// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 read responder.
// Holds the burst/resp encodings, the queued AR command record and the
// engine state encoding used by axi4_rd_responder.
package axi4_pkg;

   // Width of one generated data lane inside an R beat.
   localparam int LANE_W     = 64;
   // Queued command addresses are stored at this width; the responder
   // zero-extends its AR address into it (ADDRWIDTH must not exceed it).
   localparam int CMD_ADDR_W = 64;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef struct packed {
      logic [CMD_ADDR_W-1:0] addr;
      burst_t                burst;
      logic [7:0]            len;
      logic [2:0]            size;
   } ar_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_WAIT  = 2'b01,
      ST_BURST = 2'b10
   } eng_state_t;

   // A burst is answered with SLVERR when its type is neither FIXED nor INCR,
   // or when one beat would be wider than the data bus.
   function automatic logic cmd_is_illegal(input ar_cmd_t cmd, input logic [3:0] max_size);
      return ((cmd.burst != BURST_FIXED) && (cmd.burst != BURST_INCR)) ||
             ({1'b0, cmd.size} > max_size);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO used as the AR command queue.
// The head entry is visible combinationally on o_data so the engine can
// pop and latch a command in the same cycle. Push when full and pop when
// empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write; contents need no reset since the count gates visibility.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= ptr_inc(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

endmodule

// File: rtl/axi4_rd_responder.sv
// AXI4 read-channel slave returning address-derived data at fixed latency.
// AR commands are queued in sync_fifo; a three-state engine (IDLE, WAIT,
// BURST) replays each one as arlen+1 R beats whose 64-bit lanes carry
// beat_addr + 8*lane. Illegal bursts return SLVERR with zero data.
// Build option: define AXI4_RD_RESPONDER_THROTTLE_EN to drop rvalid for one
// cycle after every THROTTLE_PERIOD handshaked beats within a burst.
module axi4_rd_responder
   import axi4_pkg::*;
#(
   parameter int ADDRWIDTH       = 36,
   parameter int DATAWIDTH       = 1024,
   parameter int QDEPTH          = 2,
   parameter int LATENCY         = 2,
   parameter int THROTTLE_PERIOD = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDRWIDTH-1:0] s_axi_araddr,
   input  logic [1:0]           s_axi_arburst,
   input  logic [3:0]           s_axi_arcache,
   input  logic [7:0]           s_axi_arlen,
   input  logic                 s_axi_arlock,
   input  logic [2:0]           s_axi_arprot,
   input  logic [2:0]           s_axi_arsize,
   input  logic                 s_axi_arvalid,
   output logic                 s_axi_arready,
   output logic [DATAWIDTH-1:0] s_axi_rdata,
   output logic                 s_axi_rlast,
   output logic [1:0]           s_axi_rresp,
   output logic                 s_axi_rvalid,
   input  logic                 s_axi_rready,
   output logic                 busy_o
);

   localparam int         NLANES     = DATAWIDTH / LANE_W;
   localparam logic [3:0] MAX_SIZE   = 4'($clog2(DATAWIDTH / 8));
   localparam int         CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int         QCNT_W     = $clog2(QDEPTH + 1);

   // Queue interface
   ar_cmd_t               w_push_cmd;
   ar_cmd_t               w_head_cmd;
   logic [$bits(ar_cmd_t)-1:0] w_head_raw;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [QCNT_W-1:0]     w_count;
   logic [QCNT_W-1:0]     w_count_next;
   logic                  r_arready;

   // Engine
   eng_state_t            r_state;
   eng_state_t            w_state_next;
   logic [CNT_W-1:0]      r_cnt;
   logic [ADDRWIDTH-1:0]  r_addr;
   logic [ADDRWIDTH-1:0]  r_step;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic                  r_err;
   logic                  w_present;
   logic                  w_hs;
   logic                  w_thr_hit;

   // Head-command decode
   logic [ADDRWIDTH-1:0]  w_head_addr;
   logic [ADDRWIDTH-1:0]  w_size_mask;
   logic [ADDRWIDTH-1:0]  w_start_addr;
   logic [ADDRWIDTH-1:0]  w_step;

   // R channel registers
   logic                  r_rvalid;
   logic                  r_rlast;
   resp_t                 r_rresp;
   logic [DATAWIDTH-1:0]  r_rdata;
   logic [DATAWIDTH-1:0]  w_beat_data;
   logic [LANE_W-1:0]     w_addr_lane;

   logic                  w_unused;

   // Cache/lock/prot carry no meaning here; the stored address is wider
   // than ADDRWIDTH and only its low bits are replayed.
   assign w_unused = ^{s_axi_arcache, s_axi_arlock, s_axi_arprot, w_head_cmd.addr};

   assign w_push_cmd.addr  = CMD_ADDR_W'(s_axi_araddr);
   assign w_push_cmd.burst = burst_t'(s_axi_arburst);
   assign w_push_cmd.len   = s_axi_arlen;
   assign w_push_cmd.size  = s_axi_arsize;

   assign w_push       = s_axi_arvalid && r_arready;
   assign w_head_cmd   = ar_cmd_t'(w_head_raw);
   assign w_count_next = w_count + QCNT_W'(w_push) - QCNT_W'(w_pop);

   sync_fifo #(
      .WIDTH (($bits(ar_cmd_t))),
      .DEPTH (QDEPTH)
   ) u_ar_queue (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_cmd),
      .i_pop   (w_pop),
      .o_data  (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // arready looks one edge ahead at the post-push/pop occupancy, so it can
   // never admit a command into a queue that becomes full on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arready <= 1'b0;
      end else begin
         r_arready <= (w_count_next != QCNT_W'(QDEPTH));
      end
   end

   // Start address and per-beat stride of the command at the queue head.
   assign w_head_addr  = w_head_cmd.addr[ADDRWIDTH-1:0];
   assign w_size_mask  = (ADDRWIDTH'(1) << w_head_cmd.size) - ADDRWIDTH'(1);
   assign w_start_addr = (w_head_cmd.burst == BURST_INCR) ? (w_head_addr & ~w_size_mask)
                                                          : w_head_addr;
   assign w_step       = (w_head_cmd.burst == BURST_INCR) ? (ADDRWIDTH'(1) << w_head_cmd.size)
                                                          : '0;

   assign w_hs = r_rvalid && s_axi_rready;

`ifdef AXI4_RD_RESPONDER_THROTTLE_EN
   localparam int TCNT_W = $clog2(THROTTLE_PERIOD + 1);
   logic [TCNT_W-1:0] r_tcnt;

   assign w_thr_hit = (r_tcnt == TCNT_W'(THROTTLE_PERIOD - 1));

   // Handshaked-beat counter within the current burst, cleared at each pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt <= '0;
      end else if (w_pop) begin
         r_tcnt <= '0;
      end else if (w_hs && !r_rlast) begin
         r_tcnt <= w_thr_hit ? '0 : r_tcnt + TCNT_W'(1);
      end
   end
`else
   assign w_thr_hit = 1'b0;
`endif

   // Engine state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next state plus pop/present strobes. A BURST cycle with rvalid low is
   // a throttle bubble, after which the next beat is presented.
   always_comb begin
      w_state_next = r_state;
      w_pop        = 1'b0;
      w_present    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop        = 1'b1;
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_present    = 1'b1;
               w_state_next = ST_BURST;
            end
         end
         ST_BURST: begin
            if (!r_rvalid) begin
               w_present = 1'b1;
            end else if (w_hs) begin
               if (r_rlast) begin
                  w_state_next = ST_IDLE;
               end else if (!w_thr_hit) begin
                  w_present = 1'b1;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Lane k of a beat is its address plus 8*k, widened to 64 bits.
   assign w_addr_lane = LANE_W'(r_addr);
   for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
      assign w_beat_data[gi*LANE_W +: LANE_W] = w_addr_lane + LANE_W'(8 * gi);
   end

   // Working registers and R channel: latch command on pop, count latency,
   // load a beat when presenting, and clear the channel after a handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_addr   <= '0;
         r_step   <= '0;
         r_len    <= '0;
         r_beat   <= '0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
         r_rlast  <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else begin
         if (w_pop) begin
            r_addr <= w_start_addr;
            r_step <= w_step;
            r_len  <= w_head_cmd.len;
            r_err  <= cmd_is_illegal(w_head_cmd, MAX_SIZE);
            r_beat <= '0;
            r_cnt  <= CNT_W'(LATENCY - 1);
         end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end

         if (w_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rresp  <= RESP_OKAY;
         end

         if (w_present) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_err ? '0 : w_beat_data;
            r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
            r_rlast  <= (r_beat == r_len);
            r_beat   <= r_beat + 8'd1;
            r_addr   <= r_addr + r_step;
         end
      end
   end

   assign s_axi_arready = r_arready;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rlast   = r_rlast;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign busy_o        = !w_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi4_rd_responder.sv
// Directed bench for axi4_rd_responder with hand-computed expectations.
module tb_axi4_rd_responder;

   localparam int AW  = 36;
   localparam int DW  = 1024;
   localparam int LAT = 2;
`ifdef AXI4_RD_RESPONDER_THROTTLE_EN
   localparam int THR_ON = 1;
`else
   localparam int THR_ON = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] araddr;
   logic [1:0]    arburst;
   logic [3:0]    arcache;
   logic [7:0]    arlen;
   logic          arlock;
   logic [2:0]    arprot;
   logic [2:0]    arsize;
   logic          arvalid;
   logic          arready;
   logic [DW-1:0] rdata;
   logic          rlast;
   logic [1:0]    rresp;
   logic          rvalid;
   logic          rready;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int hs_cyc;
   int b_cyc;
   logic [63:0] b_l0, b_l1, b_l15;
   logic        b_last;
   logic [1:0]  b_resp;

   axi4_rd_responder #(
      .ADDRWIDTH (AW),
      .DATAWIDTH (DW),
      .QDEPTH (2),
      .LATENCY (LAT),
      .THROTTLE_PERIOD (4)
   ) dut (
      .clk (clk),
      .rst_n (rst_n),
      .s_axi_araddr (araddr),
      .s_axi_arburst (arburst),
      .s_axi_arcache (arcache),
      .s_axi_arlen (arlen),
      .s_axi_arlock (arlock),
      .s_axi_arprot (arprot),
      .s_axi_arsize (arsize),
      .s_axi_arvalid (arvalid),
      .s_axi_arready (arready),
      .s_axi_rdata (rdata),
      .s_axi_rlast (rlast),
      .s_axi_rresp (rresp),
      .s_axi_rvalid (rvalid),
      .s_axi_rready (rready),
      .busy_o (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present an AR at a falling edge and hold it until accepted.
   task automatic ar_issue(input logic [AW-1:0] a, input logic [1:0] b,
                           input logic [7:0] l, input logic [2:0] s);
      int n;
      n = 0;
      araddr = a; arburst = b; arlen = l; arsize = s; arvalid = 1'b1;
      while (arready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ar_accept", {63'd0, arready}, 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
      hs_cyc  = cyc;
      $display("AR  addr=0x%0h burst=%0d len=%0d size=%0d accepted at cycle %0d", a, b, l, s, hs_cyc);
   endtask

   // Wait for a beat (rready assumed high) and capture it.
   task automatic rx_beat();
      int n;
      n = 0;
      while (rvalid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("rx_valid", {63'd0, rvalid}, 64'd1);
      b_l0 = rdata[63:0]; b_l1 = rdata[127:64]; b_l15 = rdata[1023:960];
      b_last = rlast; b_resp = rresp; b_cyc = cyc;
      $display("R   lane0=0x%0h lane1=0x%0h last=%0d resp=%0d cycle %0d", b_l0, b_l1, b_last, b_resp, b_cyc);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int x_last_cyc;
      int seen;
      int bc [10];
      araddr = '0; arburst = 2'b01; arcache = 4'h3; arlen = '0; arlock = 1'b0;
      arprot = 3'd0; arsize = '0; arvalid = 1'b0; rready = 1'b0;

      // ---- reset values ----
      repeat (3) @(negedge clk);
      chk("rst_arready", {63'd0, arready}, 64'd0);
      chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("rst_rlast", {63'd0, rlast}, 64'd0);
      chk("rst_rresp", {62'd0, rresp}, 64'd0);
      chk("rst_rdata", {63'd0, |rdata}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arready_after_rst", {63'd0, arready}, 64'd1);

      // ---- T1: INCR 0x100, size 7, len 3 ----
      rready = 1'b1;
      ar_issue(36'h100, 2'b01, 8'd3, 3'd7);
      for (int i = 0; i < 4; i++) begin
         rx_beat();
         if (i == 0) chk("t1_latency", 64'(b_cyc - hs_cyc), 64'(LAT + 1));
         chk("t1_lane0", b_l0, 64'h100 + 64'h80 * i);
         chk("t1_lane1", b_l1, 64'h108 + 64'h80 * i);
         chk("t1_rlast", {63'd0, b_last}, 64'(i == 3));
         chk("t1_rresp", {62'd0, b_resp}, 64'd0);
      end
      chk("t1_lane15", b_l15, 64'h280 + 64'd120);
      chk("t1_rvalid_drop", {63'd0, rvalid}, 64'd0);
      repeat (2) @(negedge clk);
      chk("t1_busy_idle", {63'd0, busy}, 64'd0);

      // ---- T2: same command, beat 1 stalled for 3 cycles ----
      ar_issue(36'h100, 2'b01, 8'd3, 3'd7);
      rx_beat();
      chk("t2_b0", b_l0, 64'h100);
      rready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t2_hold_valid", {63'd0, rvalid}, 64'd1);
         chk("t2_hold_lane0", rdata[63:0], 64'h180);
         chk("t2_hold_rlast", {63'd0, rlast}, 64'd0);
      end
      rready = 1'b1;
      rx_beat();
      chk("t2_b1", b_l0, 64'h180);
      rx_beat();
      chk("t2_b2", b_l0, 64'h200);
      rx_beat();
      chk("t2_b3", b_l0, 64'h280);
      chk("t2_b3_last", {63'd0, b_last}, 64'd1);

      // ---- T3: queue fill while R is stalled ----
      rready = 1'b0;
      ar_issue(36'h1000, 2'b01, 8'd1, 3'd7);
      repeat (5) @(negedge clk);
      chk("t3_x_stalled", {63'd0, rvalid}, 64'd1);
      ar_issue(36'h2000, 2'b01, 8'd0, 3'd7);
      ar_issue(36'h3000, 2'b01, 8'd0, 3'd7);
      chk("t3_full", {63'd0, arready}, 64'd0);
      araddr = 36'h4000; arburst = 2'b01; arlen = 8'd0; arsize = 3'd7; arvalid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t3_c_wait", {63'd0, arready}, 64'd0);
      end
      chk("t3_busy", {63'd0, busy}, 64'd1);
      rready = 1'b1;
      rx_beat();
      chk("t3_x0", b_l0, 64'h1000);
      rx_beat();
      chk("t3_x1", b_l0, 64'h1080);
      chk("t3_x1_last", {63'd0, b_last}, 64'd1);
      x_last_cyc = b_cyc;
      chk("t3_ar_lag", {63'd0, arready}, 64'd0);
      @(negedge clk);
      chk("t3_ar_rise", {63'd0, arready}, 64'd1);
      @(negedge clk);
      arvalid = 1'b0;
      rx_beat();
      chk("t3_gap", 64'(b_cyc - x_last_cyc), 64'(LAT + 2));
      chk("t3_a", b_l0, 64'h2000);
      chk("t3_a_last", {63'd0, b_last}, 64'd1);
      rx_beat();
      chk("t3_b", b_l0, 64'h3000);
      rx_beat();
      chk("t3_c", b_l0, 64'h4000);

      // ---- T4: FIXED, then WRAP and reserved burst -> SLVERR ----
      rready = 1'b0;
      ar_issue(36'h40, 2'b00, 8'd2, 3'd3);
      ar_issue(36'h40, 2'b10, 8'd1, 3'd3);
      ar_issue(36'h80, 2'b11, 8'd0, 3'd3);
      rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_beat();
         chk("t4_fixed_lane0", b_l0, 64'h40);
         chk("t4_fixed_lane1", b_l1, 64'h48);
         chk("t4_fixed_resp", {62'd0, b_resp}, 64'd0);
         chk("t4_fixed_last", {63'd0, b_last}, 64'(i == 2));
      end
      for (int i = 0; i < 2; i++) begin
         rx_beat();
         chk("t4_wrap_lane0", b_l0, 64'd0);
         chk("t4_wrap_lane15", b_l15, 64'd0);
         chk("t4_wrap_resp", {62'd0, b_resp}, 64'd2);
         chk("t4_wrap_last", {63'd0, b_last}, 64'(i == 1));
      end
      rx_beat();
      chk("t4_rsvd_resp", {62'd0, b_resp}, 64'd2);
      chk("t4_rsvd_lane1", b_l1, 64'd0);
      chk("t4_rsvd_last", {63'd0, b_last}, 64'd1);

      // ---- T5: reset mid-burst with a command still queued ----
      rready = 1'b0;
      ar_issue(36'h800, 2'b01, 8'd7, 3'd7);
      ar_issue(36'hA00, 2'b01, 8'd0, 3'd7);
      rready = 1'b1;
      rx_beat();
      chk("t5_b0", b_l0, 64'h800);
      rx_beat();
      chk("t5_b1", b_l0, 64'h880);
      chk("t5_b2_present", rdata[63:0], 64'h900);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("t5_rst_busy", {63'd0, busy}, 64'd0);
      chk("t5_rst_arready", {63'd0, arready}, 64'd0);
      chk("t5_rst_rlast", {63'd0, rlast}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rvalid === 1'b1) seen++;
      end
      chk("t5_no_beats", 64'(seen), 64'd0);
      chk("t5_busy_after", {63'd0, busy}, 64'd0);
      ar_issue(36'hC00, 2'b01, 8'd1, 3'd7);
      rx_beat();
      chk("t5_new_latency", 64'(b_cyc - hs_cyc), 64'(LAT + 1));
      chk("t5_new_b0", b_l0, 64'hC00);
      chk("t5_new_b0_last", {63'd0, b_last}, 64'd0);
      rx_beat();
      chk("t5_new_b1", b_l0, 64'hC80);
      chk("t5_new_b1_last", {63'd0, b_last}, 64'd1);

      // ---- T6: 10-beat INCR stream (bubbles only with throttling) ----
      ar_issue(36'h0, 2'b01, 8'd9, 3'd3);
      for (int i = 0; i < 10; i++) begin
         rx_beat();
         bc[i] = b_cyc;
         chk("t6_lane0", b_l0, 64'd8 * i);
      end
      chk("t6_last", {63'd0, b_last}, 64'd1);
      chk("t6_span", 64'(bc[9] - bc[0]), 64'(THR_ON ? 11 : 9));
      chk("t6_gap_2_3", 64'(bc[3] - bc[2]), 64'd1);
      chk("t6_gap_3_4", 64'(bc[4] - bc[3]), 64'(THR_ON ? 2 : 1));
      chk("t6_gap_7_8", 64'(bc[8] - bc[7]), 64'(THR_ON ? 2 : 1));
      chk("t6_gap_8_9", 64'(bc[9] - bc[8]), 64'd1);
      chk("t6_after_last", {63'd0, rvalid}, 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
